// File: rtl/ro_cache_refill_if.sv
// ro_cache_refill_if: miss-port, backing-bus, data-array and tag-write signals of the refill controller.
// master is the controller side, slave the cache/bus environment side.
interface ro_cache_refill_if #(
    parameter int MEM_DEPTH  = 32,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam int OW = $clog2(LINE_WORDS);

    logic                     miss_req_0, miss_req_1;
    logic [ADDR_WIDTH-1:0]    miss_addr_0, miss_addr_1;
    logic                     miss_gnt_0, miss_gnt_1;
    logic                     miss_done_0, miss_done_1;
    logic                     bus_req;
    logic [ADDR_WIDTH-1:0]    bus_addr;
    logic                     bus_ack;
    logic                     bus_rvalid;
    logic                     bus_rready;
    logic [DATA_WIDTH-1:0]    bus_rdata;
    logic                     arr_wen;
    logic [IW-1:0]            arr_waddr;
    logic [DATA_WIDTH-1:0]    arr_wdata;
    logic                     arr_wready;
    logic                     tag_wen;
    logic [IW-OW-1:0]         tag_widx;
    logic [ADDR_WIDTH-IW-1:0] tag_wtag;

    modport master (
        input  miss_req_0, miss_req_1, miss_addr_0, miss_addr_1,
        input  bus_ack, bus_rvalid, bus_rdata, arr_wready,
        output miss_gnt_0, miss_gnt_1, miss_done_0, miss_done_1,
        output bus_req, bus_addr, bus_rready,
        output arr_wen, arr_waddr, arr_wdata,
        output tag_wen, tag_widx, tag_wtag
    );

    modport slave (
        output miss_req_0, miss_req_1, miss_addr_0, miss_addr_1,
        output bus_ack, bus_rvalid, bus_rdata, arr_wready,
        input  miss_gnt_0, miss_gnt_1, miss_done_0, miss_done_1,
        input  bus_req, bus_addr, bus_rready,
        input  arr_wen, arr_waddr, arr_wdata,
        input  tag_wen, tag_widx, tag_wtag
    );
endinterface

// File: rtl/ro_cache_refill_ctrl.sv
// ro_cache_refill_ctrl: round-robin miss-refill sequencer streaming one bus burst per line into the data array.
// Define RO_CACHE_REFILL_CWF_EN for critical-word-first bursts; otherwise bursts are line-aligned.
module ro_cache_refill_ctrl #(
    parameter int MEM_DEPTH  = 32,
    parameter int LINE_WORDS = 4,
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    ro_cache_refill_if.master cif,
    output logic              busy_o
);
    localparam int IW   = $clog2(MEM_DEPTH);
    localparam int OW   = $clog2(LINE_WORDS);
    localparam int LAST = LINE_WORDS - 1;

    typedef enum logic [1:0] {IDLE, REQ, FILL, DONE} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic                  owner_q;
    logic                  prio_q;
    logic [OW:0]           cnt_q;

    logic                  both, sel, in_idle, in_fill, in_done, xfer, co;
    logic [ADDR_WIDTH-1:0] other_addr;
    logic [OW-1:0]         off;

    assign both       = cif.miss_req_0 && cif.miss_req_1;
    assign sel        = both ? prio_q : cif.miss_req_1;
    assign in_idle    = state_q == IDLE;
    assign in_fill    = state_q == FILL;
    assign in_done    = state_q == DONE;
    assign xfer       = in_fill && cif.bus_rvalid && cif.arr_wready;
    assign other_addr = owner_q ? cif.miss_addr_0 : cif.miss_addr_1;
    // A waiting request for the line being installed is satisfied without a second burst.
    assign co = in_done && (owner_q ? cif.miss_req_0 : cif.miss_req_1)
                && other_addr[ADDR_WIDTH-1:OW] == addr_q[ADDR_WIDTH-1:OW];

`ifdef RO_CACHE_REFILL_CWF_EN
    assign off          = cnt_q[OW-1:0] + addr_q[OW-1:0];
    assign cif.bus_addr = state_q == REQ ? addr_q : '0;
`else
    assign off          = cnt_q[OW-1:0];
    assign cif.bus_addr = state_q == REQ ? {addr_q[ADDR_WIDTH-1:OW], {OW{1'b0}}} : '0;
`endif

    assign cif.miss_gnt_0  = (in_idle && cif.miss_req_0 && !sel) || (co && owner_q);
    assign cif.miss_gnt_1  = (in_idle && sel) || (co && !owner_q);
    assign cif.miss_done_0 = in_done && (!owner_q || co);
    assign cif.miss_done_1 = in_done && (owner_q || co);
    assign cif.bus_req     = state_q == REQ;
    // Holding rready low while the array stalls keeps the beat on the bus.
    assign cif.bus_rready  = in_fill && cif.arr_wready;
    assign cif.arr_wen     = in_fill && cif.bus_rvalid;
    assign cif.arr_waddr   = in_fill ? {addr_q[IW-1:OW], off} : '0;
    assign cif.arr_wdata   = in_fill ? cif.bus_rdata : '0;
    assign cif.tag_wen     = in_done;
    assign cif.tag_widx    = in_done ? addr_q[IW-1:OW] : '0;
    assign cif.tag_wtag    = in_done ? addr_q[ADDR_WIDTH-1:IW] : '0;
    assign busy_o          = !in_idle;

    // prio_q only moves on contended grants, so simultaneous pairs alternate.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            addr_q  <= '0;
            owner_q <= 1'b0;
            prio_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (cif.miss_req_0 || cif.miss_req_1) begin
                    state_q <= REQ;
                    owner_q <= sel;
                    addr_q  <= sel ? cif.miss_addr_1 : cif.miss_addr_0;
                    if (both) prio_q <= !sel;
                end
                REQ: if (cif.bus_ack) begin
                    state_q <= FILL;
                    cnt_q   <= '0;
                end
                FILL: if (xfer) begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LAST[OW:0]) state_q <= DONE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ro_cache_refill_ctrl.sv
// tb_ro_cache_refill_ctrl: directed scenarios plus random traffic against a transaction-level model of the refill controller.
// Honours RO_CACHE_REFILL_CWF_EN the same way as the design.
module tb_ro_cache_refill_ctrl;
    localparam int MD = 32, LW = 4, AW = 32, DW = 32;
`ifdef RO_CACHE_REFILL_CWF_EN
    localparam bit CWF = 1'b1;
`else
    localparam bit CWF = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic busy;
    always #5 clk = ~clk;

    ro_cache_refill_if #(.MEM_DEPTH(MD), .LINE_WORDS(LW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) cif ();
    ro_cache_refill_ctrl #(.MEM_DEPTH(MD), .LINE_WORDS(LW), .ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
        .clk(clk), .rst_n(rst_n), .cif(cif), .busy_o(busy)
    );

    int errors = 0, checks = 0, n = 0;
    bit m_act, m_own, m_acked, m_prio;
    int m_beats;
    logic [AW-1:0] m_addr;
    int ack_dly = 0, rcnt = 0, sent = 0, stall_beat = -1, stall_left = 0;
    bit strm, rv_rand, wr_rand, prev_breq;
    int gnt0_log[$], gnt1_log[$], done0_log[$], done1_log[$], wa_log[$], tidx_log[$], ttag_log[$];
    int breq_rise = 0, breq_cyc = 0, tag_cnt = 0;
    logic [AW-1:0] last_baddr;
    int e_ncwf[4] = '{16, 17, 18, 19};
    int e_cwf[4]  = '{19, 16, 17, 18};

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @cycle %0d: got %0h expected %0h", nm, n, act, exp);
        end
    endtask

    // One clock: compare/update the model at negedge, then drive stimulus #1 after posedge.
    task automatic cyc();
        logic r0, r1, sel, fill, dn, co, oreq, g0, g1, xf, ak, stall;
        logic [AW-1:0] oaddr, ba;
        int wa, off0;
        @(negedge clk);
        n++;
        r0 = cif.miss_req_0;
        r1 = cif.miss_req_1;
        if (!rst_n) begin
            m_act = 0; m_acked = 0; m_beats = 0; m_prio = 0; prev_breq = 0;
            chk("rst_busy", busy, 0);
            chk("rst_gnt", {cif.miss_gnt_0, cif.miss_gnt_1}, 0);
            chk("rst_done", {cif.miss_done_0, cif.miss_done_1}, 0);
            chk("rst_bus_req", cif.bus_req, 0);
            chk("rst_arr_wen", cif.arr_wen, 0);
            chk("rst_tag_wen", cif.tag_wen, 0);
        end else begin
            sel   = (r0 && r1) ? m_prio : r1;
            fill  = m_act && m_acked && m_beats < LW;
            dn    = m_act && m_acked && m_beats == LW;
            oreq  = m_own ? r0 : r1;
            oaddr = m_own ? cif.miss_addr_0 : cif.miss_addr_1;
            co    = dn && oreq && (oaddr / LW == m_addr / LW);
            g0    = (!m_act && r0 && !sel) || (co && m_own);
            g1    = (!m_act && r1 && sel) || (co && !m_own);
            off0  = CWF ? int'(m_addr % LW) : 0;
            wa    = int'(m_addr / LW % (MD / LW)) * LW + (off0 + m_beats) % LW;
            ba    = CWF ? m_addr : m_addr - m_addr % LW;
            chk("gnt0", cif.miss_gnt_0, g0);
            chk("gnt1", cif.miss_gnt_1, g1);
            chk("busy", busy, m_act);
            chk("bus_req", cif.bus_req, m_act && !m_acked);
            chk("bus_addr", cif.bus_addr, (m_act && !m_acked) ? ba : 0);
            chk("bus_rready", cif.bus_rready, fill && cif.arr_wready);
            chk("arr_wen", cif.arr_wen, fill && cif.bus_rvalid);
            chk("arr_waddr", cif.arr_waddr, fill ? wa : 0);
            chk("arr_wdata", cif.arr_wdata, fill ? cif.bus_rdata : 0);
            chk("tag_wen", cif.tag_wen, dn);
            chk("tag_widx", cif.tag_widx, dn ? m_addr / LW % (MD / LW) : 0);
            chk("tag_wtag", cif.tag_wtag, dn ? m_addr / MD : 0);
            chk("done0", cif.miss_done_0, dn && (!m_own || co));
            chk("done1", cif.miss_done_1, dn && (m_own || co));
            if (cif.miss_gnt_0) gnt0_log.push_back(n);
            if (cif.miss_gnt_1) gnt1_log.push_back(n);
            if (cif.miss_done_0) done0_log.push_back(n);
            if (cif.miss_done_1) done1_log.push_back(n);
            if (cif.arr_wen && cif.arr_wready) wa_log.push_back(int'(cif.arr_waddr));
            if (cif.tag_wen) begin
                tag_cnt++;
                tidx_log.push_back(int'(cif.tag_widx));
                ttag_log.push_back(int'(cif.tag_wtag));
            end
            if (cif.bus_req) begin
                breq_cyc++;
                last_baddr = cif.bus_addr;
                if (!prev_breq) breq_rise++;
            end
            prev_breq = cif.bus_req;
            if (!m_act && (r0 || r1)) begin
                m_act = 1; m_own = sel; m_acked = 0; m_beats = 0;
                m_addr = sel ? cif.miss_addr_1 : cif.miss_addr_0;
                if (r0 && r1) m_prio = !sel;
            end else if (m_act && !m_acked) m_acked = cif.bus_ack;
            else if (fill) begin
                if (cif.bus_rvalid && cif.arr_wready) m_beats++;
            end else if (dn) m_act = 0;
        end
        g0 = cif.miss_gnt_0;
        g1 = cif.miss_gnt_1;
        xf = cif.bus_rvalid && cif.bus_rready;
        ak = cif.bus_req && cif.bus_ack;
        @(posedge clk);
        #1;
        if (g0) cif.miss_req_0 = 0;
        if (g1) cif.miss_req_1 = 0;
        if (ak) begin strm = 1; sent = 0; end
        else if (xf) sent++;
        if (sent == LW) strm = 0;
        cif.bus_ack = cif.bus_req && rcnt >= ack_dly;
        rcnt = cif.bus_req ? rcnt + 1 : 0;
        cif.bus_rvalid = strm && (!rv_rand || $urandom_range(0, 3) != 0);
        cif.bus_rdata = $urandom;
        stall = strm && sent == stall_beat && stall_left > 0;
        if (stall) stall_left--;
        cif.arr_wready = !stall && (!wr_rand || $urandom_range(0, 2) != 0);
    endtask

    task automatic run_idle(input int max, input string nm);
        int k = 0;
        do begin
            cyc();
            k++;
        end while ((cif.miss_req_0 || cif.miss_req_1 || busy) && k < max);
        chk({nm, "_finished"}, k < max, 1);
    endtask

    function automatic logic [AW-1:0] raddr();
        logic [AW-1:0] a;
        a = AW'($urandom_range(0, 47));
        if ($urandom_range(0, 3) == 0) a[AW-1:5] = 27'($urandom);
        return a;
    endfunction

    initial begin
        int b, g0, g1, d0, d1, t, r, q, tc;
        cif.miss_req_0 = 0; cif.miss_req_1 = 0; cif.miss_addr_0 = '0; cif.miss_addr_1 = '0;
        cif.bus_ack = 0; cif.bus_rvalid = 0; cif.bus_rdata = '0; cif.arr_wready = 1;
        repeat (3) cyc();
        rst_n = 1;
        cyc();

        // single miss, port 0
        b = wa_log.size(); g0 = gnt0_log.size(); d0 = done0_log.size(); t = tidx_log.size();
        cif.miss_addr_0 = 32'h13; cif.miss_req_0 = 1;
        run_idle(40, "s1");
        for (int k = 0; k < 4; k++) chk("s1_waddr", wa_log[b + k], CWF ? e_cwf[k] : e_ncwf[k]);
        chk("s1_writes", wa_log.size() - b, 4);
        chk("s1_idx", tidx_log[t], 4);
        chk("s1_tag", ttag_log[t], 0);
        chk("s1_latency", done0_log[d0] - gnt0_log[g0], 6);

        // contended pair, then a second pair goes to port 1 first
        g0 = gnt0_log.size(); g1 = gnt1_log.size(); d0 = done0_log.size();
        cif.miss_addr_0 = 32'h20; cif.miss_addr_1 = 32'h44; cif.miss_req_0 = 1; cif.miss_req_1 = 1;
        run_idle(60, "s2a");
        chk("s2a_p0_first", gnt0_log[g0] < gnt1_log[g1], 1);
        chk("s2a_gap", gnt1_log[g1] - done0_log[d0], 1);
        g0 = gnt0_log.size(); g1 = gnt1_log.size();
        cif.miss_addr_0 = 32'h64; cif.miss_addr_1 = 32'h08; cif.miss_req_0 = 1; cif.miss_req_1 = 1;
        run_idle(60, "s2b");
        chk("s2b_p1_first", gnt1_log[g1] < gnt0_log[g0], 1);

        // coalesce
        r = breq_rise; d0 = done0_log.size(); d1 = done1_log.size(); g1 = gnt1_log.size(); tc = tag_cnt;
        cif.miss_addr_0 = 32'h48; cif.miss_req_0 = 1;
        repeat (4) cyc();
        cif.miss_addr_1 = 32'h4A; cif.miss_req_1 = 1;
        run_idle(40, "s3");
        chk("s3_same_done", done0_log[d0] == done1_log[d1], 1);
        chk("s3_gnt_in_done", gnt1_log[g1] == done1_log[d1], 1);
        chk("s3_bursts", breq_rise - r, 1);
        chk("s3_tag_writes", tag_cnt - tc, 1);

        // array backpressure on beat 2
        b = wa_log.size(); g1 = gnt1_log.size(); d1 = done1_log.size();
        stall_beat = 2; stall_left = 3;
        cif.miss_addr_1 = 32'h1C; cif.miss_req_1 = 1;
        run_idle(40, "s4");
        chk("s4_writes", wa_log.size() - b, 4);
        chk("s4_latency", done1_log[d1] - gnt1_log[g1], 9);
        stall_beat = -1;

        // late bus_ack
        q = breq_cyc; g0 = gnt0_log.size(); d0 = done0_log.size();
        ack_dly = 5;
        cif.miss_addr_0 = 32'h2B; cif.miss_req_0 = 1;
        run_idle(40, "s5");
        chk("s5_req_cycles", breq_cyc - q, 6);
        chk("s5_bus_addr", last_baddr, CWF ? 32'h2B : 32'h28);
        chk("s5_latency", done0_log[d0] - gnt0_log[g0], 11);
        ack_dly = 0;

        // reset mid-burst
        b = wa_log.size(); tc = tag_cnt; d0 = done0_log.size();
        cif.miss_addr_0 = 32'h35; cif.miss_req_0 = 1;
        for (int k = 0; k < 20 && wa_log.size() < b + 2; k++) cyc();
        chk("s6_reached_beat", wa_log.size() >= b + 2, 1);
        rst_n = 0;
        cif.miss_req_0 = 0; cif.miss_req_1 = 0; cif.bus_ack = 0; cif.bus_rvalid = 0;
        strm = 0; sent = 0; rcnt = 0;
        cyc(); cyc();
        rst_n = 1;
        cyc();
        chk("s6_busy", busy, 0);
        chk("s6_no_tag", tag_cnt - tc, 0);
        chk("s6_no_done", done0_log.size() - d0, 0);
        b = wa_log.size();
        cif.miss_addr_0 = 32'h35; cif.miss_req_0 = 1;
        run_idle(40, "s6b");
        chk("s6_refill_writes", wa_log.size() - b, 4);
        chk("s6_refill_done", done0_log.size() - d0, 1);

        // random traffic
        rv_rand = 1; wr_rand = 1;
        for (int k = 0; k < 800; k++) begin
            if (!cif.miss_req_0 && $urandom_range(0, 3) == 0) begin
                cif.miss_addr_0 = raddr(); cif.miss_req_0 = 1;
            end
            if (!cif.miss_req_1 && $urandom_range(0, 3) == 0) begin
                cif.miss_addr_1 = raddr(); cif.miss_req_1 = 1;
            end
            ack_dly = $urandom_range(0, 3);
            cyc();
        end
        run_idle(300, "s7");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
